// File: rtl/fft_stream_chk.sv
// ============================================================================
//  Module   : fft_stream_chk
//  Purpose  : Sink/checker for the FFT output stream. It checks frame
//             structure (bin index 0..FFT_LENGTH, last only on the final bin),
//             tracks the peak-magnitude bin of each frame, counts good frames
//             and keeps a sticky error flag with a first-error code.
//  Ports    : sys_clk, sys_rst       - clock, synchronous active-high reset
//             s_axi_data/user/last/valid - stream beat (no backpressure)
//             err_clr                - clears err / err_code
//             frame_done             - 1-cycle pulse per good frame
//             frame_cnt              - good frame counter (wraps)
//             peak_idx / peak_mag    - peak bin and |re|+|im| of last good frame
//             err / err_code         - sticky error, first code since clear
//                                      (1 start, 2 index, 3 last, 4 timeout)
//  Options  : FFT_CHK_TIMEOUT_EN - enables the in-frame idle gap timeout
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_stream_chk #(
    parameter int FFT_LENGTH = 1023,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int TIMEOUT    = 4095
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [2*DATA_WIDTH-1:0] s_axi_data,
    input  logic [ADDR_WIDTH:0]     s_axi_user,
    input  logic                    s_axi_last,
    input  logic                    s_axi_valid,
    input  logic                    err_clr,
    output logic                    frame_done,
    output logic [15:0]             frame_cnt,
    output logic [ADDR_WIDTH:0]     peak_idx,
    output logic [DATA_WIDTH:0]     peak_mag,
    output logic                    err,
    output logic [2:0]              err_code
);

    localparam int                  C_IDX_W     = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] C_LAST_IDX  = C_IDX_W'(FFT_LENGTH);
    localparam logic [2:0]          C_ERR_START = 3'd1;
    localparam logic [2:0]          C_ERR_INDEX = 3'd2;
    localparam logic [2:0]          C_ERR_LAST  = 3'd3;

    // The index counter must cover exactly one frame without wrapping.
    generate
        if (FFT_LENGTH != (1 << C_IDX_W) - 1 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
            $error("fft_stream_chk: FFT_LENGTH must be 2**(ADDR_WIDTH+1)-1 and TIMEOUT in 1..65535");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH:0]   r_exp, w_exp_nxt;
    logic [DATA_WIDTH:0]   r_run_mag, w_run_mag_nxt;
    logic [ADDR_WIDTH:0]   r_run_idx, w_run_idx_nxt;
    logic                  w_err_det;
    logic [2:0]            w_err_new;
    logic                  w_good;

    // |re| + |im|. The two's complement negate of the most negative value
    // yields 2^(DATA_WIDTH-1) when read as unsigned, which is the true magnitude.
    logic [DATA_WIDTH-1:0] w_re, w_im, w_abs_re, w_abs_im;
    logic [DATA_WIDTH:0]   w_mag;

    assign w_re     = s_axi_data[DATA_WIDTH-1:0];
    assign w_im     = s_axi_data[2*DATA_WIDTH-1:DATA_WIDTH];
    assign w_abs_re = w_re[DATA_WIDTH-1] ? (~w_re + 1'b1) : w_re;
    assign w_abs_im = w_im[DATA_WIDTH-1] ? (~w_im + 1'b1) : w_im;
    assign w_mag    = {1'b0, w_abs_re} + {1'b0, w_abs_im};

`ifdef FFT_CHK_TIMEOUT_EN
    localparam logic [15:0] C_TIMEOUT   = 16'(TIMEOUT);
    localparam logic [2:0]  C_ERR_TMO   = 3'd4;
    logic [15:0]            r_gap, w_gap_nxt;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_exp_nxt     = r_exp;
        w_run_mag_nxt = r_run_mag;
        w_run_idx_nxt = r_run_idx;
        w_err_det     = 1'b0;
        w_err_new     = 3'd0;
        w_good        = 1'b0;
`ifdef FFT_CHK_TIMEOUT_EN
        w_gap_nxt     = r_gap;
`endif
        case (r_state)
            ST_IDLE: begin
`ifdef FFT_CHK_TIMEOUT_EN
                w_gap_nxt = 16'd0;
`endif
                if (s_axi_valid) begin
                    if (s_axi_user != '0) begin
                        w_err_det = 1'b1;
                        w_err_new = C_ERR_START;
                    end else if (s_axi_last) begin
                        w_err_det = 1'b1;
                        w_err_new = C_ERR_LAST;
                    end else begin
                        w_state_nxt   = ST_RECV;
                        w_run_mag_nxt = w_mag;
                        w_run_idx_nxt = '0;
                        w_exp_nxt     = C_IDX_W'(1);
                    end
                end
            end
            ST_RECV: begin
                if (s_axi_valid) begin
`ifdef FFT_CHK_TIMEOUT_EN
                    w_gap_nxt = 16'd0;
`endif
                    if (s_axi_user != r_exp) begin
                        w_err_det   = 1'b1;
                        w_err_new   = C_ERR_INDEX;
                        w_state_nxt = ST_IDLE;
                    end else if (s_axi_last != (r_exp == C_LAST_IDX)) begin
                        w_err_det   = 1'b1;
                        w_err_new   = C_ERR_LAST;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        // Strictly greater: ties keep the earlier bin.
                        if (w_mag > r_run_mag) begin
                            w_run_mag_nxt = w_mag;
                            w_run_idx_nxt = s_axi_user;
                        end
                        w_exp_nxt = r_exp + 1'b1;
                        if (s_axi_last) begin
                            w_good      = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end else begin
`ifdef FFT_CHK_TIMEOUT_EN
                    w_gap_nxt = r_gap + 16'd1;
                    if (w_gap_nxt == C_TIMEOUT) begin
                        w_err_det   = 1'b1;
                        w_err_new   = C_ERR_TMO;
                        w_state_nxt = ST_IDLE;
                        w_gap_nxt   = 16'd0;
                    end
`endif
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_exp      <= '0;
            r_run_mag  <= '0;
            r_run_idx  <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= 16'd0;
            peak_idx   <= '0;
            peak_mag   <= '0;
            err        <= 1'b0;
            err_code   <= 3'd0;
`ifdef FFT_CHK_TIMEOUT_EN
            r_gap      <= 16'd0;
`endif
        end else begin
            r_exp      <= w_exp_nxt;
            r_run_mag  <= w_run_mag_nxt;
            r_run_idx  <= w_run_idx_nxt;
            frame_done <= w_good;
`ifdef FFT_CHK_TIMEOUT_EN
            r_gap      <= w_gap_nxt;
`endif
            if (w_good) begin
                frame_cnt <= frame_cnt + 16'd1;
                peak_idx  <= w_run_idx_nxt;
                peak_mag  <= w_run_mag_nxt;
            end
            // A new error beats a simultaneous clear; otherwise the first code sticks.
            if (w_err_det) begin
                err <= 1'b1;
                if (err_clr || err_code == 3'd0) begin
                    err_code <= w_err_new;
                end
            end else if (err_clr) begin
                err      <= 1'b0;
                err_code <= 3'd0;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/fft_stream_chk.md
Name: fft_stream_chk

Overview:
Sink/checker for the FFT output stream that fft_rd drives on its m_axi_* ports (data, bin index on user, last, valid; no backpressure).
- Verifies frame structure: bin index sequence 0..FFT_LENGTH, and last on bin FFT_LENGTH only.
- Extracts the peak-magnitude bin of each frame and counts good frames.
- Raises a sticky error flag for LED/status aggregation in the test top.

Parameters:
FFT_LENGTH, 1023, index of the final bin (frame = FFT_LENGTH+1 beats)
DATA_WIDTH, 16, width of each of re/im in the stream word
ADDR_WIDTH, 9, user index width is ADDR_WIDTH+1
TIMEOUT, 4095, max idle cycles inside a frame (used only with the optional feature)

Ports:
sys_clk  input  1  clock
sys_rst  input  1  synchronous active-high reset
s_axi_data  input  2*DATA_WIDTH  {im[DATA_WIDTH-1:0], re[DATA_WIDTH-1:0]}, two's complement
s_axi_user  input  ADDR_WIDTH+1  bin index
s_axi_last  input  1  last beat of frame
s_axi_valid  input  1  beat qualifier
err_clr  input  1  clears err and err_code
frame_done  output  1  one-cycle pulse per good frame
frame_cnt  output  16  count of good frames
peak_idx  output  ADDR_WIDTH+1  bin of max magnitude, last good frame
peak_mag  output  DATA_WIDTH+1  max magnitude, last good frame
err  output  1  sticky error
err_code  output  3  first error since clear: 0 none, 1 start, 2 index, 3 last, 4 timeout

Behaviour:
- Clock and reset: one clock, sys_clk. sys_rst is synchronous, active-high, and takes priority over all other inputs.
- Reset values: all outputs 0, state IDLE, expected index 0, running peak 0.
- The FSM advances only on beats (s_axi_valid=1). Non-valid cycles hold state.
- Magnitude per beat: |re|+|im|, unsigned, DATA_WIDTH+1 bits.
  - |-2^(DATA_WIDTH-1)| = 2^(DATA_WIDTH-1); no saturation needed.
- IDLE:
  - Beat with user==0 and last==0: go to RECV, load running peak = {mag, 0}, exp = 1.
  - Beat with user!=0: error code 1, stay in IDLE, beat discarded.
  - Beat with user==0 and last==1: error code 3, stay in IDLE.
- RECV, on each beat:
  - If user!=exp: error code 2, go to IDLE. The frame is discarded, with no frame_done and no count.
  - Else if last!=(exp==FFT_LENGTH): error code 3, go to IDLE, frame discarded.
  - Else: update the running peak on strictly greater magnitude (ties keep the earlier bin), then exp = exp+1.
  - On the final beat (exp==FFT_LENGTH with last=1):
    - Register peak_idx/peak_mag including that beat.
    - Pulse frame_done on the next cycle.
    - frame_cnt+1, wrapping 0xFFFF->0.
    - Go to IDLE.
- Latency: frame_done, peak_* and frame_cnt all update in the cycle after the last beat is sampled. peak_* hold until the next good frame.
- Back-to-back frames: a user==0 beat in the cycle right after the last beat is accepted as a new frame start. There is no dead cycle.
- Error capture:
  - err is set on any error.
  - err_code records only the first error; later errors do not overwrite a nonzero code.
  - err_clr zeroes both. If err_clr coincides with a new error, the new error wins: err=1 and err_code = the new error's code.
- FFT_LENGTH must equal 2^(ADDR_WIDTH+1)-1. The exp counter is ADDR_WIDTH+1 bits; no wrap occurs within a valid frame.
- Reset mid-frame: the partial frame is dropped, outputs clear, and the next user==0 beat starts cleanly.

Optional Feature:
FFT_CHK_TIMEOUT_EN
- Defined:
  - A 16-bit gap counter runs in RECV. It clears on every beat and increments on non-valid cycles.
  - When it reaches TIMEOUT, record error code 4 and go to IDLE; the partial frame is dropped.
  - The counter holds at 0 in IDLE.
- Undefined: no gap counter and no code 4. RECV waits indefinitely; TIMEOUT is unused.

Test Plan:
1. Two back-to-back clean frames (user 0..1023, last on 1023, data 0 except bin 37 re=-32768 im=100) -> two frame_done pulses, frame_cnt=2, peak_idx=37, peak_mag=32868, err=0.
2. Ties: bins 5 and 9 both re=1000 im=0, rest 0 -> peak_idx=5, peak_mag=1000.
3. Index skip (bin 200 followed by 202) -> err=1, err_code=2, no frame_done; next clean frame -> frame_done, frame_cnt=1, err stays 1 with code 2.
4. Last asserted at bin 500, then a first beat with user=3 in IDLE -> err_code=3 (not 1); err_clr asserted the same cycle as a user!=0 beat in IDLE -> err=1, err_code=1.
5. sys_rst pulsed at bin 700 -> all outputs 0; restart at user 0 gives frame_done after 1024 beats, frame_cnt=1.
6. (FFT_CHK_TIMEOUT_EN, TIMEOUT=16) valid dropped for 16 cycles at bin 10 -> err_code=4, state IDLE; a 15-cycle gap -> no error.
